bip_run_ctrl: RTL

Execution and debug controller for the BIP processor. Gates the CPU clock-enable for run, single-step and halt, and shares the data-memory port between the CPU and a host-side dump engine. The dump engine streams all CELDAS data cells out over a valid/ready interface. Sits between the host command interface and the cpu/datamemory pair inside the BIP top.

---
 rtl/bip_ctrl_pkg.sv | 39 +++
 rtl/bip_dm_dump.sv | 72 +++++++
 rtl/bip_run_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bip_ctrl_pkg.sv
// Shared encodings for the BIP run/debug controller: host command codes,
// the externally visible state code and the top-level control modes.
package bip_ctrl_pkg;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_DUMP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_HALTED    = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_OUT  = 3'd6
    } state_e;

    // Top-level mode; the three dump phases collapse into C_DUMP here and are
    // tracked by the dump engine itself.
    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_RUN    = 3'd1,
        C_STEP   = 3'd2,
        C_HALTED = 3'd3,
        C_DUMP   = 3'd4
    } ctrl_e;

    function automatic state_e ctrl_state(input ctrl_e c);
        case (c)
            C_RUN:    return ST_RUN;
            C_STEP:   return ST_STEP;
            C_HALTED: return ST_HALTED;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bip_dm_dump.sv
// Data-memory dump engine: reads cells 0..CELDAS-1 one at a time and offers
// each word on a valid/ready stream, holding it stable until accepted.
module bip_dm_dump
    import bip_ctrl_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int CELDAS  = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               dump_ready_i,
    input  logic [NBITS_D-1:0] dm_rdata_i,
    output logic               done_o,
    output state_e             phase_o,
    output logic               dm_rd_o,
    output logic [NBITS_O-1:0] dm_addr_o,
    output logic               dump_valid_o,
    output logic [NBITS_O-1:0] dump_addr_o,
    output logic [NBITS_D-1:0] dump_data_o
);

    localparam logic [NBITS_O-1:0] LAST = NBITS_O'(CELDAS - 1);

    state_e             phase_q;
    logic [NBITS_O-1:0] ptr_q;
    logic [NBITS_O-1:0] addr_q;
    logic [NBITS_D-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (phase_q)
                ST_DUMP_RD: phase_q <= ST_DUMP_WAIT;
                ST_DUMP_WAIT: begin
                    data_q  <= dm_rdata_i;
                    addr_q  <= ptr_q;
                    phase_q <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (dump_ready_i) begin
                        if (ptr_q == LAST) begin
                            ptr_q   <= '0;
                            phase_q <= ST_IDLE;
                        end else begin
                            ptr_q   <= ptr_q + NBITS_O'(1);
                            phase_q <= ST_DUMP_RD;
                        end
                    end
                end
                default: begin
                    if (start_i) phase_q <= ST_DUMP_RD;
                end
            endcase
        end
    end

    // Completion is combinational so the top FSM leaves on the same edge as the last handshake.
    assign done_o       = (phase_q == ST_DUMP_OUT) && dump_ready_i && (ptr_q == LAST);
    assign phase_o      = phase_q;
    assign dm_rd_o      = (phase_q == ST_DUMP_RD);
    assign dm_addr_o    = (phase_q == ST_DUMP_RD) ? ptr_q : '0;
    assign dump_valid_o = (phase_q == ST_DUMP_OUT);
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;

endmodule

// File: rtl/bip_run_ctrl.sv
// BIP execution/debug controller: gates the CPU enable for run/step/halt and
// shares the data-memory port with the dump engine. Breakpoints: BIP_BREAKPOINT_EN.
module bip_run_ctrl
    import bip_ctrl_pkg::*;
#(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int CELDAS    = 10,
    parameter int NBITS_CNT = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_cpu_halt,
    output logic                 o_cpu_en,
    input  logic [NBITS_O-1:0]   i_cpu_dm_addr,
    input  logic                 i_cpu_rd,
    input  logic                 i_cpu_wr,
    input  logic [NBITS_D-1:0]   i_cpu_wdata,
    output logic [NBITS_O-1:0]   o_dm_addr,
    output logic                 o_dm_rd,
    output logic                 o_dm_wr,
    output logic [NBITS_D-1:0]   o_dm_wdata,
    input  logic [NBITS_D-1:0]   i_dm_rdata,
    output logic                 o_dump_valid,
    input  logic                 i_dump_ready,
    output logic [NBITS_O-1:0]   o_dump_addr,
    output logic [NBITS_D-1:0]   o_dump_data,
    output logic [2:0]           o_state,
    output logic [NBITS_CNT-1:0] o_cycle_cnt
`ifdef BIP_BREAKPOINT_EN
    ,
    input  logic [NBITS_O-1:0]   i_cpu_pm_addr,
    input  logic [NBITS_O-1:0]   i_bp_addr,
    input  logic                 i_bp_en,
    output logic                 o_bp_hit
`endif
);

    ctrl_e                ctrl_q;
    ctrl_e                ret_q;
    logic [NBITS_CNT-1:0] cnt_q;
    logic [NBITS_CNT-1:0] cnt_d;
    logic                 cmd_ready;
    logic                 cmd_acc;
    logic                 abort_acc;
    logic                 cpu_en;
    logic                 dump_start;
    logic                 dump_done;
    logic                 bp_match;
    state_e               dump_phase;
    logic                 dump_rd;
    logic [NBITS_O-1:0]   dump_dm_addr;

    assign cmd_ready  = (ctrl_q == C_IDLE) || (ctrl_q == C_RUN) || (ctrl_q == C_HALTED);
    assign cmd_acc    = i_cmd_valid && cmd_ready;
    assign abort_acc  = cmd_acc && (i_cmd == CMD_ABORT);
    assign dump_start = cmd_acc && (i_cmd == CMD_DUMP)
                        && ((ctrl_q == C_IDLE) || (ctrl_q == C_HALTED));

`ifdef BIP_BREAKPOINT_EN
    logic first_q;
    logic bp_hit_q;

    // first_q marks the first RUN cycle so a RUN issued at a breakpoint moves past it.
    assign bp_match = (ctrl_q == C_RUN) && !first_q && i_bp_en && (i_cpu_pm_addr == i_bp_addr);
    assign o_bp_hit = bp_hit_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= (ctrl_q == C_IDLE) && cmd_acc && (i_cmd == CMD_RUN);
            bp_hit_q <= bp_match;
        end
    end
`else
    assign bp_match = 1'b0;
`endif

    assign cpu_en = ((ctrl_q == C_RUN) && !bp_match) || (ctrl_q == C_STEP);

    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en && (cnt_q != '1)) cnt_d = cnt_q + NBITS_CNT'(1);
        if (abort_acc && ((ctrl_q == C_RUN) || (ctrl_q == C_HALTED))) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ctrl_q <= C_IDLE;
            ret_q  <= C_IDLE;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (ctrl_q)
                C_IDLE: begin
                    if (cmd_acc) begin
                        case (i_cmd)
                            CMD_RUN:  ctrl_q <= C_RUN;
                            CMD_STEP: ctrl_q <= C_STEP;
                            CMD_DUMP: begin
                                ctrl_q <= C_DUMP;
                                ret_q  <= C_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                C_RUN: begin
                    if (abort_acc)       ctrl_q <= C_IDLE;
                    else if (bp_match)   ctrl_q <= C_IDLE;
                    else if (i_cpu_halt) ctrl_q <= C_HALTED;
                end
                C_STEP: ctrl_q <= i_cpu_halt ? C_HALTED : C_IDLE;
                C_HALTED: begin
                    if (dump_start) begin
                        ctrl_q <= C_DUMP;
                        ret_q  <= C_HALTED;
                    end else if (abort_acc) begin
                        ctrl_q <= C_IDLE;
                    end
                end
                C_DUMP: begin
                    if (dump_done) ctrl_q <= ret_q;
                end
                default: ctrl_q <= C_IDLE;
            endcase
        end
    end

    bip_dm_dump #(
        .NBITS_O (NBITS_O),
        .NBITS_D (NBITS_D),
        .CELDAS  (CELDAS)
    ) u_dump (
        .clk_i        (i_clk),
        .rst_ni       (i_reset),
        .start_i      (dump_start),
        .dump_ready_i (i_dump_ready),
        .dm_rdata_i   (i_dm_rdata),
        .done_o       (dump_done),
        .phase_o      (dump_phase),
        .dm_rd_o      (dump_rd),
        .dm_addr_o    (dump_dm_addr),
        .dump_valid_o (o_dump_valid),
        .dump_addr_o  (o_dump_addr),
        .dump_data_o  (o_dump_data)
    );

    // The CPU owns the memory port whenever it is enabled; the controller only ever reads.
    always_comb begin
        if (cpu_en) begin
            o_dm_addr  = i_cpu_dm_addr;
            o_dm_rd    = i_cpu_rd;
            o_dm_wr    = i_cpu_wr;
            o_dm_wdata = i_cpu_wdata;
        end else begin
            o_dm_addr  = dump_dm_addr;
            o_dm_rd    = dump_rd;
            o_dm_wr    = 1'b0;
            o_dm_wdata = '0;
        end
    end

    assign o_cmd_ready = cmd_ready;
    assign o_cpu_en    = cpu_en;
    assign o_cycle_cnt = cnt_q;
    assign o_state     = (ctrl_q == C_DUMP) ? dump_phase : ctrl_state(ctrl_q);

endmodule
